// File: rtl/seq_mult_8_bit.sv
// seq_mult_8_bit: sequential 8x8 unsigned shift-and-add multiplier.
// It reuses one 8-bit ripple-carry adder for eight iterations and
// hands the 16-bit product back through a start/done handshake.

// rca_8_bit: plain 8-bit ripple-carry adder shared by the multiplier iterations.
module rca_8_bit (
   input  logic [7:0] i_a,
   input  logic [7:0] i_b,
   input  logic       i_cin,
   output logic [7:0] o_sum,
   output logic       o_cout
);

   // Ripple the carry bit by bit, LSB first.
   always_comb begin
      logic [8:0] c;
      c     = '0;
      o_sum = '0;
      c[0]  = i_cin;
      for (int i = 0; i < 8; i++) begin
         o_sum[i] = i_a[i] ^ i_b[i] ^ c[i];
         c[i+1]   = (i_a[i] & i_b[i]) | (c[i] & (i_a[i] ^ i_b[i]));
      end
      o_cout = c[8];
   end

endmodule

module seq_mult_8_bit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [7:0]  a,
   input  logic [7:0]  b,
   output logic        busy,
   output logic        done,
   output logic [15:0] product
);

   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [DATA_W-1:0]   r_m;
   logic [DATA_W-1:0]   r_q;
   logic [DATA_W-1:0]   r_acc;
   logic [3:0]          r_cnt;
   logic [2*DATA_W-1:0] r_product;
   logic [DATA_W-1:0]   w_addend;
   logic [DATA_W-1:0]   w_sum;
   logic                w_cout;
   logic                w_last;

   // Add the multiplicand only when the current multiplier LSB is set.
   assign w_addend = r_q[0] ? r_m : '0;
   assign w_last   = (r_cnt == 4'd7);

   rca_8_bit u_rca (
      .i_a    (r_acc),
      .i_b    (w_addend),
      .i_cin  (1'b0),
      .o_sum  (w_sum),
      .o_cout (w_cout)
   );

   // State register; reset forces IDLE immediately so busy/done drop at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode: accept start only in IDLE, eight RUN edges, one DONE cycle.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_RUN;
         S_RUN:   if (w_last) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Operand capture, shift-and-add iteration and result latch on the final iteration.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_m       <= '0;
         r_q       <= '0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_product <= '0;
      end else begin
         if (r_state == S_IDLE && start) begin
            r_m   <= a;
            r_q   <= b;
            r_acc <= '0;
            r_cnt <= '0;
         end else if (r_state == S_RUN) begin
            // {cout,sum} shifted right one place across the A:Q pair.
            r_acc <= {w_cout, w_sum[DATA_W-1:1]};
            r_q   <= {w_sum[0], r_q[DATA_W-1:1]};
            r_cnt <= r_cnt + 4'd1;
            if (w_last) begin
               r_product <= {w_cout, w_sum[DATA_W-1:1], w_sum[0], r_q[DATA_W-1:1]};
            end
         end
      end
   end

   assign busy    = (r_state == S_RUN);
   assign done    = (r_state == S_DONE);
   assign product = r_product;

endmodule

// File: tb/tb_seq_mult_8_bit.sv
// tb_seq_mult_8_bit: directed and swept checks of the sequential multiplier.
module tb_seq_mult_8_bit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        busy;
   logic        done;
   logic [15:0] product;

   int          n_checks;
   int          n_errors;
   logic [15:0] last_prod;

   seq_mult_8_bit dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .product (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One full operation from E0 to E9, checking the whole handshake schedule.
   task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic [15:0] exp);
      a = ta;
      b = tb_v;
      start = 1'b1;
      tick();                                   // E0
      start = 1'b0;
      a = ~ta;                                  // operands must not be resampled
      b = ~tb_v;
      check("e0_busy", {15'd0, busy}, 16'd1);
      check("e0_done", {15'd0, done}, 16'd0);
      for (int k = 1; k <= 7; k++) begin
         tick();                                // E1..E7
         check("run_busy", {15'd0, busy}, 16'd1);
         check("run_done", {15'd0, done}, 16'd0);
         check("run_prod_hold", product, last_prod);
      end
      tick();                                   // E8
      check("e8_busy", {15'd0, busy}, 16'd0);
      check("e8_done", {15'd0, done}, 16'd1);
      check("e8_prod", product, exp);
      tick();                                   // E9
      check("e9_busy", {15'd0, busy}, 16'd0);
      check("e9_done", {15'd0, done}, 16'd0);
      check("e9_prod", product, exp);
      last_prod = exp;
   endtask

   initial begin
      logic [7:0]  ra;
      logic [7:0]  rb;
      logic [15:0] rexp;
      n_checks  = 0;
      n_errors  = 0;
      last_prod = 16'h0000;
      rst_n = 1'b0;
      start = 1'b0;
      a = 8'h00;
      b = 8'h00;
      tick();
      tick();
      check("rst_busy", {15'd0, busy}, 16'd0);
      check("rst_done", {15'd0, done}, 16'd0);
      check("rst_prod", product, 16'h0000);
      rst_n = 1'b1;
      tick();
      check("idle_busy", {15'd0, busy}, 16'd0);

      // Basic products from the test list.
      run_op(8'd13, 8'd11, 16'h008F);
      run_op(8'hFF, 8'hFF, 16'hFE01);
      run_op(8'h00, 8'hFF, 16'h0000);

      // start held high: back-to-back operations exactly 10 cycles apart.
      a = 8'h80;
      b = 8'h02;
      start = 1'b1;
      tick();                                   // E0
      check("held_e0_busy", {15'd0, busy}, 16'd1);
      a = 8'h01;
      b = 8'h01;
      for (int k = 1; k <= 7; k++) begin
         tick();
         check("held_run_busy", {15'd0, busy}, 16'd1);
      end
      tick();                                   // E8
      check("held_e8_done", {15'd0, done}, 16'd1);
      check("held_e8_prod", product, 16'h0100);
      tick();                                   // E9
      check("held_e9_busy", {15'd0, busy}, 16'd0);
      check("held_e9_done", {15'd0, done}, 16'd0);
      tick();                                   // second E0
      check("held_e0b_busy", {15'd0, busy}, 16'd1);
      for (int k = 1; k <= 7; k++) begin
         tick();
         check("held_run2_busy", {15'd0, busy}, 16'd1);
         check("held_run2_prod", product, 16'h0100);
      end
      tick();                                   // second E8
      start = 1'b0;
      check("held_e8b_done", {15'd0, done}, 16'd1);
      check("held_e8b_prod", product, 16'h0001);
      tick();
      check("held_e9b_done", {15'd0, done}, 16'd0);
      last_prod = 16'h0001;

      // start pulsed during RUN is ignored.
      a = 8'd3;
      b = 8'd5;
      start = 1'b1;
      tick();                                   // E0
      start = 1'b0;
      tick();
      tick();
      a = 8'hFF;
      b = 8'hFF;
      start = 1'b1;
      tick();                                   // E3
      start = 1'b0;
      for (int k = 4; k <= 7; k++) begin
         tick();
         check("ign_busy", {15'd0, busy}, 16'd1);
         check("ign_done", {15'd0, done}, 16'd0);
      end
      tick();                                   // E8
      check("ign_e8_done", {15'd0, done}, 16'd1);
      check("ign_e8_prod", product, 16'h000F);
      for (int k = 0; k < 4; k++) begin
         tick();
         check("ign_after_done", {15'd0, done}, 16'd0);
         check("ign_after_busy", {15'd0, busy}, 16'd0);
         check("ign_after_prod", product, 16'h000F);
      end
      last_prod = 16'h000F;

      // Asynchronous reset mid-RUN at cnt=4, between edges.
      a = 8'd9;
      b = 8'd9;
      start = 1'b1;
      tick();                                   // E0
      start = 1'b0;
      for (int k = 1; k <= 4; k++) tick();      // after E4, cnt=4
      check("mid_busy_pre", {15'd0, busy}, 16'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", {15'd0, busy}, 16'd0);
      check("mid_rst_done", {15'd0, done}, 16'd0);
      check("mid_rst_prod", product, 16'h0000);
      rst_n = 1'b1;
      last_prod = 16'h0000;
      tick();
      check("mid_idle_busy", {15'd0, busy}, 16'd0);
      check("mid_idle_done", {15'd0, done}, 16'd0);
      run_op(8'd2, 8'd7, 16'h000E);

      // Random sweep against the arithmetic reference.
      for (int n = 0; n < 1000; n++) begin
         ra   = 8'($urandom_range(0, 255));
         rb   = 8'($urandom_range(0, 255));
         rexp = {8'h00, ra} * {8'h00, rb};
         run_op(ra, rb, rexp);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
